// File: rtl/ddr3_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_bus_pkg
// Description : Shared widths and FSM state encoding for the DDR3 user-port
//               bus (test master and slave_ddr3).
// Revision    : 1.0 - initial release
// ============================================================================
package ddr3_bus_pkg;

  localparam int BUS_ADDR_W = 28;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_LEN_W  = 8;

  // Test sequence: address write, data write, address read, data read.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WA   = 3'd1,
    ST_WD   = 3'd2,
    ST_RA   = 3'd3,
    ST_RD   = 3'd4
  } bus_state_e;

endpackage : ddr3_bus_pkg
`default_nettype wire

// File: rtl/ddr3_bus_test_master.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_bus_test_master
// Description : Writes one incrementing-pattern burst to the slave_ddr3 user
//               port, reads it back and counts data/protocol mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_bus_test_master
  import ddr3_bus_pkg::*;
#(
  parameter logic [31:0] SEED  = 32'h0000_0000,
  parameter int          ERR_W = 16
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  start,
  input  logic [BUS_ADDR_W-1:0] base_addr,
  input  logic [BUS_LEN_W-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [BUS_ADDR_W-1:0] WR_ADDR,
  output logic [BUS_LEN_W-1:0]  WR_LEN,
  output logic                  WR_ADDR_VALID,
  input  logic                  WR_ADDR_READY,
  output logic [BUS_DATA_W-1:0] WR_DATA,
  output logic [3:0]            WR_STRB,
  output logic                  WR_DATA_VALID,
  input  logic                  WR_DATA_READY,
  output logic                  WR_DATA_LAST,
  output logic [BUS_ADDR_W-1:0] RD_ADDR,
  output logic [BUS_LEN_W-1:0]  RD_LEN,
  output logic                  RD_ADDR_VALID,
  input  logic                  RD_ADDR_READY,
  input  logic [BUS_DATA_W-1:0] RD_DATA,
  input  logic                  RD_DATA_LAST,
  output logic                  RD_DATA_READY,
  input  logic                  RD_DATA_VALID
);

  localparam logic [ERR_W-1:0] c_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam int               c_PAD_W   = BUS_DATA_W - BUS_LEN_W;

  bus_state_e            r_state;
  bus_state_e            w_state_next;
  logic [BUS_ADDR_W-1:0] r_addr;
  logic [BUS_LEN_W-1:0]  r_len;
  logic [BUS_LEN_W-1:0]  r_wb;
  logic [BUS_LEN_W-1:0]  r_rb;
  logic [ERR_W-1:0]      r_err;
  logic                  r_pass;
  logic                  r_done;

  logic                  w_start_acc;
  logic                  w_wa_hs;
  logic                  w_wd_hs;
  logic                  w_ra_hs;
  logic                  w_rd_hs;
  logic [BUS_DATA_W-1:0] w_rd_exp;
  logic                  w_beat_err;
  logic [ERR_W-1:0]      w_err_next;

  // Handshakes: each VALID/READY owned by this side is a pure decode of the
  // state, so it can only fall when the state leaves on a completed beat.
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_wa_hs     = (r_state == ST_WA) && WR_ADDR_READY;
  assign w_wd_hs     = (r_state == ST_WD) && WR_DATA_READY;
  assign w_ra_hs     = (r_state == ST_RA) && RD_ADDR_READY;
  assign w_rd_hs     = (r_state == ST_RD) && RD_DATA_VALID;

  // Checker: a beat is bad on wrong data or on LAST in the wrong place.
  assign w_rd_exp   = SEED + {{c_PAD_W{1'b0}}, r_rb};
  assign w_beat_err = (RD_DATA != w_rd_exp) || (RD_DATA_LAST != (r_rb == r_len));
  assign w_err_next = (w_beat_err && !(&r_err)) ? (r_err + c_ERR_ONE) : r_err;

  // State register.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; an early RD_DATA_LAST still ends the readback.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)                      w_state_next = ST_WA;
      ST_WA:   if (w_wa_hs)                    w_state_next = ST_WD;
      ST_WD:   if (w_wd_hs && WR_DATA_LAST)    w_state_next = ST_RA;
      ST_RA:   if (w_ra_hs)                    w_state_next = ST_RD;
      ST_RD:   if (w_rd_hs && RD_DATA_LAST)    w_state_next = ST_IDLE;
      default:                                 w_state_next = ST_IDLE;
    endcase
  end

  // Burst parameters, beat counters and result registers.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_addr <= '0;
      r_len  <= '0;
      r_wb   <= '0;
      r_rb   <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_acc) begin
        r_addr <= base_addr;
        r_len  <= burst_len;
        r_wb   <= '0;
        r_rb   <= '0;
        r_err  <= '0;
        r_pass <= 1'b0;
      end
      if (w_wd_hs) begin
        r_wb <= r_wb + 1'b1;
      end
      if (w_rd_hs) begin
        r_err <= w_err_next;
        r_rb  <= r_rb + 1'b1;
        if (RD_DATA_LAST) begin
          r_done <= 1'b1;
          r_pass <= (w_err_next == '0);
        end
      end
    end
  end

  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_cnt       = r_err;
  assign WR_ADDR       = r_addr;
  assign WR_LEN        = r_len;
  assign WR_ADDR_VALID = (r_state == ST_WA);
  assign WR_DATA       = SEED + {{c_PAD_W{1'b0}}, r_wb};
  assign WR_STRB       = 4'hF;
  assign WR_DATA_VALID = (r_state == ST_WD);
  assign WR_DATA_LAST  = (r_wb == r_len);
  assign RD_ADDR       = r_addr;
  assign RD_LEN        = r_len;
  assign RD_ADDR_VALID = (r_state == ST_RA);
  assign RD_DATA_READY = (r_state == ST_RD);

endmodule : ddr3_bus_test_master
`default_nettype wire

// File: tb/tb_ddr3_bus_test_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_bus_test_master
// Description : Directed self-checking bench with a small DDR3 user-port
//               memory model (optional READY/VALID stalls, corruption,
//               early LAST, mid-burst reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_bus_test_master;

  localparam logic [31:0] c_SEED  = 32'hFFFF_FFF0;  // pattern wraps at beat 16
  localparam int          c_ERR_W = 4;              // saturates at 15

  logic               BUS_CLK = 1'b0;
  logic               BUS_RST;
  logic               start;
  logic [27:0]        base_addr;
  logic [7:0]         burst_len;
  logic               busy, done, pass;
  logic [c_ERR_W-1:0] err_cnt;
  logic [27:0]        WR_ADDR, RD_ADDR;
  logic [7:0]         WR_LEN, RD_LEN;
  logic               WR_ADDR_VALID, WR_ADDR_READY;
  logic [31:0]        WR_DATA;
  logic [3:0]         WR_STRB;
  logic               WR_DATA_VALID, WR_DATA_READY, WR_DATA_LAST;
  logic               RD_ADDR_VALID, RD_ADDR_READY;
  logic [31:0]        RD_DATA;
  logic               RD_DATA_LAST, RD_DATA_READY, RD_DATA_VALID;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [0:255];

  always #5 BUS_CLK = ~BUS_CLK;

  ddr3_bus_test_master #(.SEED(c_SEED), .ERR_W(c_ERR_W)) u_dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .start(start),
    .base_addr(base_addr), .burst_len(burst_len),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN),
    .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB),
    .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
    .WR_DATA_LAST(WR_DATA_LAST),
    .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN),
    .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
    .RD_DATA(RD_DATA), .RD_DATA_LAST(RD_DATA_LAST),
    .RD_DATA_READY(RD_DATA_READY), .RD_DATA_VALID(RD_DATA_VALID)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full test: start, then act as the memory cycle by cycle on negedges.
  task automatic run_burst(
    input  string       tag,
    input  logic [27:0] a,
    input  logic [7:0]  l,
    input  bit          stall,
    input  int          bad0,
    input  int          bad1,
    input  bit          bad_all,
    input  int          early,
    input  int          rst_beat,
    input  bit          poke_start,
    output int          wr_n,
    output int          rd_n,
    output bit          got_done
  );
    int proto_err = 0;
    int pat_err   = 0;
    int rbeat     = 0;
    bit rd_on     = 0;
    bit rv_q      = 0;
    bit rdy_q     = 0;
    bit aw_hold = 0, w_hold = 0, ar_hold = 0;
    logic [27:0] h_aa = '0, h_ra = '0;
    logic [7:0]  h_al = '0, h_rl = '0;
    logic [31:0] h_wd = '0;
    logic        h_wl = 1'b0;
    wr_n = 0; rd_n = 0; got_done = 0;

    @(negedge BUS_CLK);
    start = 1'b1; base_addr = a; burst_len = l;
    @(negedge BUS_CLK);
    start = 1'b0; base_addr = 28'hABC_DEF0; burst_len = 8'd99;
    check({tag, "_busy_t1"}, {31'd0, busy}, 32'd1);
    check({tag, "_awvalid_t1"}, {31'd0, WR_ADDR_VALID}, 32'd1);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) @(negedge BUS_CLK);
      // A stalled VALID must persist with unchanged payload.
      if (aw_hold && (!WR_ADDR_VALID || WR_ADDR !== h_aa || WR_LEN !== h_al)) proto_err++;
      if (w_hold && (!WR_DATA_VALID || WR_DATA !== h_wd || WR_DATA_LAST !== h_wl)) proto_err++;
      if (ar_hold && (!RD_ADDR_VALID || RD_ADDR !== h_ra || RD_LEN !== h_rl)) proto_err++;
      // Read beat accepted at the previous posedge.
      if (rv_q && rdy_q) begin
        if (RD_DATA_LAST) rd_on = 0;
        rbeat++; rd_n++;
        RD_DATA_VALID = 1'b0;
      end
      if (done) begin
        got_done = 1;
        if (busy) proto_err++;
        break;
      end
      if (!busy) proto_err++;
      if ($countones({WR_ADDR_VALID, WR_DATA_VALID, RD_ADDR_VALID, RD_DATA_READY}) > 1) proto_err++;
      if (rst_beat >= 0 && wr_n == rst_beat) begin
        BUS_RST = 1'b1;
        break;
      end
      if (poke_start) begin
        start = (cyc == 7); base_addr = 28'hFFF_FFFF; burst_len = 8'd3;
      end
      WR_ADDR_READY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      WR_DATA_READY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      RD_ADDR_READY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (WR_ADDR_VALID && WR_ADDR_READY && (WR_ADDR !== a || WR_LEN !== l)) pat_err++;
      aw_hold = WR_ADDR_VALID && !WR_ADDR_READY; h_aa = WR_ADDR; h_al = WR_LEN;
      if (WR_DATA_VALID && WR_DATA_READY) begin
        if (WR_DATA !== c_SEED + 32'(wr_n) || WR_DATA_LAST !== (wr_n == int'(l))) pat_err++;
        mem[8'(wr_n)] = WR_DATA;
        wr_n++;
      end
      w_hold = WR_DATA_VALID && !WR_DATA_READY; h_wd = WR_DATA; h_wl = WR_DATA_LAST;
      if (RD_ADDR_VALID && RD_ADDR_READY) begin
        if (RD_ADDR !== a || RD_LEN !== l) pat_err++;
        rd_on = 1;
      end
      ar_hold = RD_ADDR_VALID && !RD_ADDR_READY; h_ra = RD_ADDR; h_rl = RD_LEN;
      if (rd_on && !RD_DATA_VALID) RD_DATA_VALID = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (RD_DATA_VALID) begin
        RD_DATA = mem[8'(rbeat)] ^ ((bad_all || rbeat == bad0 || rbeat == bad1) ? 32'h1 : 32'h0);
        RD_DATA_LAST = (rbeat == int'(l)) || (rbeat == early);
      end
      rv_q = RD_DATA_VALID; rdy_q = RD_DATA_READY;
    end
    start = 1'b0;
    RD_DATA_VALID = 1'b0; RD_DATA_LAST = 1'b0;
    check({tag, "_protocol"}, 32'(proto_err), 32'd0);
    check({tag, "_pattern"}, 32'(pat_err), 32'd0);
  endtask

  initial begin
    int wr_n, rd_n;
    bit gd;
    BUS_RST = 1'b1; start = 1'b0; base_addr = '0; burst_len = '0;
    WR_ADDR_READY = 1'b0; WR_DATA_READY = 1'b0; RD_ADDR_READY = 1'b0;
    RD_DATA = '0; RD_DATA_LAST = 1'b0; RD_DATA_VALID = 1'b0;
    repeat (3) @(negedge BUS_CLK);

    // Reset state.
    check("rst_valids", {28'd0, WR_ADDR_VALID, WR_DATA_VALID, RD_ADDR_VALID, RD_DATA_READY}, 32'd0);
    check("rst_flags", {29'd0, busy, done, pass}, 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_wdata", WR_DATA, c_SEED);
    check("rst_strb", 32'(WR_STRB), 32'hF);
    BUS_RST = 1'b0;

    // Test 1: always ready, long burst crossing the pattern wrap.
    run_burst("t1", 28'h000_1005, 8'd167, 0, -1, -1, 0, -1, -1, 0, wr_n, rd_n, gd);
    check("t1_done", 32'(gd), 32'd1);
    check("t1_wr_beats", 32'(wr_n), 32'd168);
    check("t1_rd_beats", 32'(rd_n), 32'd168);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_cnt), 32'd0);
    @(negedge BUS_CLK);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_pass_hold", 32'(pass), 32'd1);

    // Test 2: single-beat burst.
    run_burst("t2", 28'h0AB_CDE0, 8'd0, 0, -1, -1, 0, -1, -1, 0, wr_n, rd_n, gd);
    check("t2_done", 32'(gd), 32'd1);
    check("t2_beats", 32'((wr_n << 8) | rd_n), 32'h101);
    check("t2_pass", 32'(pass), 32'd1);
    check("t2_err", 32'(err_cnt), 32'd0);

    // Test 3: random stalls everywhere plus a start pulse while busy.
    run_burst("t3", 28'h000_1005, 8'd167, 1, -1, -1, 0, -1, -1, 1, wr_n, rd_n, gd);
    check("t3_done", 32'(gd), 32'd1);
    check("t3_beats", 32'((wr_n << 8) | rd_n), 32'((168 << 8) | 168));
    check("t3_pass", 32'(pass), 32'd1);
    check("t3_err", 32'(err_cnt), 32'd0);

    // Test 4a: two corrupted read beats.
    run_burst("t4a", 28'h200_0000, 8'd167, 0, 5, 100, 0, -1, -1, 0, wr_n, rd_n, gd);
    check("t4a_done", 32'(gd), 32'd1);
    check("t4a_err", 32'(err_cnt), 32'd2);
    check("t4a_pass", 32'(pass), 32'd0);
    repeat (3) @(negedge BUS_CLK);
    check("t4a_err_hold", 32'(err_cnt), 32'd2);

    // Test 4b: RD_DATA_LAST on beat 10 of a 21-beat burst.
    run_burst("t4b", 28'h300_0040, 8'd20, 0, -1, -1, 0, 10, -1, 0, wr_n, rd_n, gd);
    check("t4b_done", 32'(gd), 32'd1);
    check("t4b_rd_beats", 32'(rd_n), 32'd11);
    check("t4b_err", 32'(err_cnt), 32'd1);
    check("t4b_pass", 32'(pass), 32'd0);

    // Test 5: reset at write beat 50, then a fresh test.
    run_burst("t5r", 28'h000_1005, 8'd167, 0, -1, -1, 0, -1, 50, 0, wr_n, rd_n, gd);
    @(negedge BUS_CLK);
    check("t5_valids", {28'd0, WR_ADDR_VALID, WR_DATA_VALID, RD_ADDR_VALID, RD_DATA_READY}, 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_wdata", WR_DATA, c_SEED);
    check("t5_err", 32'(err_cnt), 32'd0);
    BUS_RST = 1'b0;
    run_burst("t5", 28'h011_2233, 8'd30, 0, -1, -1, 0, -1, -1, 0, wr_n, rd_n, gd);
    check("t5_done", 32'(gd), 32'd1);
    check("t5_pass", 32'(pass), 32'd1);

    // Test 6: every beat corrupted -> counter saturates.
    run_burst("t6", 28'h000_0100, 8'd19, 0, -1, -1, 1, -1, -1, 0, wr_n, rd_n, gd);
    check("t6_done", 32'(gd), 32'd1);
    check("t6_err_sat", 32'(err_cnt), 32'd15);
    check("t6_pass", 32'(pass), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ddr3_bus_test_master
`default_nettype wire
